// File: rtl/adc_9226_rx.sv
// AD9226 capture front end: ADC clock divider, pipeline-latency discard,
// offset-binary to two's complement conversion and a show-ahead sample FIFO.
// Optional out-of-range saturation is enabled by defining ADC9226_OTR_EN.
module adc_9226_rx #(
  parameter int DATA_W       = 12,
  parameter int CLK_DIV      = 2,
  parameter int PIPE_DISCARD = 7,
  parameter int FIFO_AW      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_en,
  input  logic [DATA_W-1:0] I_adc_data,
`ifdef ADC9226_OTR_EN
  input  logic              I_adc_otr,
`endif
  output logic              O_adc_clkDriver,
  output logic [DATA_W-1:0] O_data,
  output logic              O_valid,
  input  logic              I_ready,
  input  logic              I_clr_ovf,
  output logic              O_overflow,
  output logic [7:0]        O_ovf_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_N = 2 * CLK_DIV;
  localparam int DIV_W = $clog2(DIV_N);
  localparam int DSC_W = (PIPE_DISCARD > 0) ? $clog2(PIPE_DISCARD + 1) : 1;
  localparam int CNT_W = FIFO_AW + 1;

  // Out-of-range codes saturate toward the rail indicated by the raw MSB.
  function automatic logic [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] raw, input logic otr);
    logic [DATA_W-1:0] res;
    if (otr) begin
      res = raw[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = {~raw[DATA_W-1], raw[DATA_W-2:0]};
    end
    return res;
  endfunction

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               clk_drv_q, clk_drv_d;
  logic [DSC_W-1:0]   disc_q, disc_d;
  logic [DATA_W-1:0]  raw_q, raw_d;
  logic               wr_pend_q, wr_pend_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         ovf_cnt_q, ovf_cnt_d;
  logic               strobe_s, pop_s, full_s, wr_en_s, drop_s, otr_s;
  logic [DATA_W-1:0]  wdata_s;

`ifdef ADC9226_OTR_EN
  logic otr_q, otr_d;
  assign otr_s = otr_q;
`else
  assign otr_s = 1'b0;
`endif

  always_comb begin
    div_cnt_d = '0;
    strobe_s  = I_en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    if (I_en) begin
      div_cnt_d = (div_cnt_q == DIV_W'(DIV_N - 1)) ? '0 : div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = '0;
    end
    clk_drv_d = I_en && (div_cnt_d < DIV_W'(CLK_DIV));

    raw_d = raw_q;
`ifdef ADC9226_OTR_EN
    otr_d = otr_q;
    if (strobe_s) begin
      otr_d = I_adc_otr;
    end else begin
      otr_d = otr_q;
    end
`endif
    if (strobe_s) begin
      raw_d = I_adc_data;
    end else begin
      raw_d = raw_q;
    end

    // A strobe while the discard count is nonzero consumes one pipeline-latency sample.
    disc_d    = disc_q;
    wr_pend_d = strobe_s && (disc_q == '0);
    if (!I_en) begin
      disc_d = DSC_W'(PIPE_DISCARD);
    end else if (strobe_s && (disc_q != '0)) begin
      disc_d = disc_q - DSC_W'(1);
    end else begin
      disc_d = disc_q;
    end

    full_s  = (cnt_q == CNT_W'(DEPTH));
    pop_s   = valid_q && I_ready;
    wr_en_s = wr_pend_q && (!full_s || pop_s);
    drop_s  = wr_pend_q && full_s && !pop_s;
    wdata_s = to_twos(raw_q, otr_s);

    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata_s;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = wr_en_s ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Head is taken from next-state memory so a write into an empty FIFO is visible at once.
    valid_d = (cnt_d != '0);
    data_d  = valid_d ? mem_d[rd_ptr_d] : '0;

    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (I_clr_ovf) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = 8'd0;
    end else if (drop_s) begin
      ovf_d     = 1'b1;
      ovf_cnt_d = (ovf_cnt_q == 8'd255) ? ovf_cnt_q : ovf_cnt_q + 8'd1;
    end else begin
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_d_unused_guard: begin end
      div_cnt_q <= '0;
      clk_drv_q <= 1'b0;
      disc_q    <= DSC_W'(PIPE_DISCARD);
      raw_q     <= '0;
`ifdef ADC9226_OTR_EN
      otr_q     <= 1'b0;
`endif
      wr_pend_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_drv_q <= clk_drv_d;
      disc_q    <= disc_d;
      raw_q     <= raw_d;
`ifdef ADC9226_OTR_EN
      otr_q     <= otr_d;
`endif
      wr_pend_q <= wr_pend_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign O_adc_clkDriver = clk_drv_q;
  assign O_data          = data_q;
  assign O_valid         = valid_q;
  assign O_overflow      = ovf_q;
  assign O_ovf_cnt       = ovf_cnt_q;

endmodule

// File: tb/tb_adc_9226_rx.sv
// Randomised and directed bench for adc_9226_rx against a queue-based reference model.
module tb_adc_9226_rx;
  localparam int DATA_W = 12, CLK_DIV = 2, PIPE_DISCARD = 7, FIFO_AW = 2;
  localparam int DEPTH = 1 << FIFO_AW;

  logic clk = 1'b0;
  logic rst, en, ready, clr;
  logic [11:0] data;
  logic clkdrv, valid, ovf;
  logic [11:0] odata;
  logic [7:0] ovf_cnt;
`ifdef ADC9226_OTR_EN
  logic otr;
`endif

  always #5 clk = ~clk;

  adc_9226_rx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .PIPE_DISCARD(PIPE_DISCARD), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .I_en(en), .I_adc_data(data),
`ifdef ADC9226_OTR_EN
    .I_adc_otr(otr),
`endif
    .O_adc_clkDriver(clkdrv), .O_data(odata), .O_valid(valid), .I_ready(ready),
    .I_clr_ovf(clr), .O_overflow(ovf), .O_ovf_cnt(ovf_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed value of an offset-binary code, or the saturated rail when out of range.
  function automatic logic [11:0] conv(input logic [11:0] code, input logic o);
    int v;
    if (o) v = (code >= 12'd2048) ? 2047 : -2048;
    else   v = int'(code) - 2048;
    return v[11:0];
  endfunction

  // Reference model state
  int m_phase = 0;
  int m_disc = PIPE_DISCARD;
  bit m_clk = 1'b0, m_pend = 1'b0, m_ovf = 1'b0;
  int m_cnt = 0;
  logic [11:0] m_pend_val = 12'd0;
  logic [11:0] m_q[$];
  logic [11:0] m_pops[$];

  function automatic int pop_at(input int i);
    return (m_pops.size() > i) ? int'(m_pops[i]) : 32'hDEAD;
  endfunction

  always @(posedge clk) begin : model
    bit pop, full, drop, strobe, o;
    if (rst) begin
      m_phase = 0; m_disc = PIPE_DISCARD; m_clk = 1'b0; m_pend = 1'b0;
      m_ovf = 1'b0; m_cnt = 0; m_q.delete();
    end else begin
      pop  = (m_q.size() > 0) && ready;
      full = (m_q.size() == DEPTH);
      if (pop) m_pops.push_back(m_q.pop_front());
      drop = 1'b0;
      if (m_pend) begin
        if (full && !pop) drop = 1'b1;
        else m_q.push_back(m_pend_val);
      end
      if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
      else if (drop) begin m_ovf = 1'b1; if (m_cnt < 255) m_cnt++; end
`ifdef ADC9226_OTR_EN
      o = otr;
`else
      o = 1'b0;
`endif
      strobe = en && (m_phase == CLK_DIV - 1);
      m_pend = 1'b0;
      if (strobe) begin
        if (m_disc > 0) m_disc--;
        else begin m_pend = 1'b1; m_pend_val = conv(data, o); end
      end
      if (!en) m_disc = PIPE_DISCARD;
      m_phase = en ? (m_phase + 1) % (2 * CLK_DIV) : 0;
      m_clk = en && (m_phase < CLK_DIV);
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("clk_drv", int'(clkdrv), int'(m_clk));
    check("valid", int'(valid), (m_q.size() > 0) ? 1 : 0);
    check("data", int'(odata), (m_q.size() > 0) ? int'(m_q[0]) : 0);
    check("overflow", int'(ovf), int'(m_ovf));
    check("ovf_cnt", int'(ovf_cnt), m_cnt);
  end

  // One 2*CLK_DIV window holds exactly one strobe when windows start aligned to enable.
  task automatic put_sample(input logic [11:0] code);
    data = code;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  initial begin
    int rises;
    logic prev;
    rst = 1'b1; en = 1'b0; ready = 1'b0; clr = 1'b0; data = 12'h800;
`ifdef ADC9226_OTR_EN
    otr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(odata), 0);
    check("rst_clk", int'(clkdrv), 0);
    check("rst_ovf_cnt", int'(ovf_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp: discard sequence then 0,1,2,...
    ready = 1'b1; en = 1'b1;
    repeat (PIPE_DISCARD) put_sample(12'h800);
    m_pops.delete();
    for (int k = 0; k < 12; k++) put_sample(12'h800 + 12'(k));
    check("ramp0", pop_at(0), 12'h000);
    check("ramp1", pop_at(1), 12'h001);
    check("ramp2", pop_at(2), 12'h002);
    rises = 0; prev = clkdrv;
    repeat (40) begin
      @(negedge clk);
      if (clkdrv && !prev) rises++;
      prev = clkdrv;
    end
    check("clk_period", rises, 10);

    // Conversion extremes
    m_pops.delete();
    put_sample(12'h000); put_sample(12'hFFF); put_sample(12'h800);
    check("code_min", pop_at(0), 12'h800);
    check("code_max", pop_at(1), 12'h7FF);
    check("code_mid", pop_at(2), 12'h000);

    // Overflow: 6 strobes into a depth-4 FIFO with no consumer
    ready = 1'b0;
    m_pops.delete();
    for (int k = 0; k < 6; k++) put_sample(12'h810 + 12'(k));
    check("ovf_flag", int'(ovf), 1);
    check("ovf_cnt2", int'(ovf_cnt), 2);
    clr = 1'b1;
    put_sample(12'h816);
    clr = 1'b0;
    check("clr_wins_flag", int'(ovf), 0);
    check("clr_wins_cnt", int'(ovf_cnt), 0);

    // Full FIFO with pop and write on the same edge
    data = 12'h817;
    @(negedge clk); @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("full_pop_cnt", int'(ovf_cnt), 0);
    check("full_pop_occ", m_q.size(), 4);
    check("full_pop_head", pop_at(0), 12'h010);

    // Disable with data buffered; clock must stay low and FIFO drainable
    en = 1'b0;
    rises = 0;
    repeat (20) begin @(negedge clk); if (clkdrv) rises++; end
    check("dis_clk_low", rises, 0);
    m_pops.delete();
    ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drain0", pop_at(0), 12'h011);
    check("drain1", pop_at(1), 12'h012);
    check("drain2", pop_at(2), 12'h013);
    check("drain3", pop_at(3), 12'h017);

    // Re-enable: discard repeats
    m_pops.delete();
    en = 1'b1;
    repeat (PIPE_DISCARD) put_sample(12'hABC);
    put_sample(12'h9A5);
    repeat (4) @(negedge clk);
    check("reen_first", pop_at(0), 12'h1A5);

`ifdef ADC9226_OTR_EN
    m_pops.delete();
    otr = 1'b1;
    put_sample(12'hF00); put_sample(12'h010);
    otr = 1'b0;
    repeat (4) @(negedge clk);
    check("otr_hi", pop_at(0), 12'h7FF);
    check("otr_lo", pop_at(1), 12'h800);
`endif

    // Random traffic
    repeat (1500) begin
      @(negedge clk);
      data  = 12'($urandom);
      ready = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr   = ($urandom_range(0, 31) == 0);
`ifdef ADC9226_OTR_EN
      otr   = ($urandom_range(0, 7) == 0);
`endif
    end

    // Reset mid-stream
    en = 1'b1; ready = 1'b0; clr = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_data", int'(odata), 0);
    check("mid_rst_clk", int'(clkdrv), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    rst = 1'b0; ready = 1'b1;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_9226_rx.md
# adc_9226_rx

Capture front end for the AD9226 12-bit ADC, the input-side counterpart of the AD9767 DAC driver. Generates the ADC sample clock from the system clock, latches the parallel ADC code at a fixed phase, discards the converter's pipeline-latency samples after enable, converts offset binary to two's complement, and buffers the samples in a small FIFO. Downstream logic, such as the frequency measurement or divider datapath, pulls samples through a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 12, ADC code width.
- `CLK_DIV`, 2, ADC clock half-period in `clk` cycles (≥1); ADC clock = f_clk / (2·CLK_DIV).
- `PIPE_DISCARD`, 7, samples dropped after each enable rising edge (AD9226 pipeline latency).
- `FIFO_AW`, 2, FIFO address width; depth = 2^FIFO_AW.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `I_en`  in  1  capture enable.
- `I_adc_data`  in  DATA_W  ADC parallel output code, offset binary.
- `I_adc_otr`  in  1  ADC out-of-range flag; present only with `ADC9226_OTR_EN`.
- `O_adc_clkDriver`  out  1  ADC sample clock.
- `O_data`  out  DATA_W  FIFO head sample, two's complement.
- `O_valid`  out  1  FIFO non-empty.
- `I_ready`  in  1  consumer accepts `O_data` when `O_valid & I_ready`.
- `I_clr_ovf`  in  1  clears `O_overflow` and `O_ovf_cnt`.
- `O_overflow`  out  1  sticky: at least one sample was dropped because the FIFO was full.
- `O_ovf_cnt`  out  8  dropped-sample count, saturates at 255.

## Operation
- Divider `div_cnt` counts 0..2·CLK_DIV−1 and wraps. `O_adc_clkDriver` is registered, high while `div_cnt < CLK_DIV`.
- Capture strobe occurs at `div_cnt == CLK_DIV−1`, the last high-phase cycle. `I_adc_data` is registered on that cycle.
- `I_en` low: `div_cnt` is held at 0, `O_adc_clkDriver` is 0, no captures occur, and the discard counter reloads to `PIPE_DISCARD`. FIFO contents are retained and remain drainable.
- Discard counter: each strobe while the counter is nonzero decrements it and drops the sample. Once the counter reaches 0, each strobe produces a write.
- Conversion: `O_data` code = raw code with the MSB inverted. 0x000→−2048, 0x800→0, 0xFFF→+2047.
- FIFO: depth 2^FIFO_AW, show-ahead. `O_data` always reflects the head entry and is 0 when empty. `O_valid` = !empty.
- Write while full without a simultaneous pop: the sample is dropped, `O_overflow` is set, and `O_ovf_cnt` increments (saturating at 255).
- Write while full with a simultaneous pop: the write is accepted and nothing is dropped.
- Pop while empty: ignored.
- `I_clr_ovf` coinciding with a drop: the clear wins. The result is flag=0 and cnt=0.

## Timing
- Reset values: `O_adc_clkDriver`=0, `O_data`=0, `O_valid`=0, `O_overflow`=0, `O_ovf_cnt`=0. Divider, discard counter (=PIPE_DISCARD), and FIFO pointers are reset; the FIFO is empty.
- A reset asserted mid-operation takes effect at the next edge. Buffered samples are lost, and the discard sequence restarts when capture resumes.
- Latency: strobe cycle registers the raw code. The next cycle writes the FIFO. `O_valid` rises on the cycle after that, 2 `clk` after the strobe when the FIFO was empty.
- The first accepted sample after `I_en` rises is the (PIPE_DISCARD+1)th strobe.
- Pop is seen at the edge where `O_valid & I_ready`. The next head appears on the following cycle; zero-bubble back-to-back pops are supported.
- Throughput: one sample per 2·CLK_DIV cycles.

## Configuration
- `ADC9226_OTR_EN` defined:
  - `I_adc_otr` exists and is registered alongside the data.
  - A captured sample with OTR=1 is saturated: raw MSB=1 → +2047, else −2048.
  - Discard and overflow rules apply unchanged.
- Not defined: `I_adc_otr` is absent, and codes pass through the MSB-inversion conversion only.

## Test plan
- Reset, then `I_en`=1, CLK_DIV=2, `I_ready`=1, ADC ramp 0x800,0x801,… → `O_adc_clkDriver` has a period of 4 `clk`. The first 7 strobes are dropped, and `O_data` then shows 0,1,2,… in two's complement, one sample per 4 cycles.
- Codes 0x000, 0xFFF, 0x800 → `O_data` shows −2048, +2047, 0.
- `I_ready`=0 for 6 strobes with depth 4 → the FIFO holds the first 4 samples, `O_overflow`=1, `O_ovf_cnt`=2. After `I_ready`=1, the original 4 samples drain in order.
- FIFO full with a pop and a strobe write on the same cycle → no drop, `O_ovf_cnt` unchanged, and occupancy stays at 4.
- `I_en` dropped mid-stream, then re-raised → the clock is held low while disabled. The 7-sample discard repeats after re-enable, and samples buffered earlier stay drainable. `rst` asserted mid-stream empties the FIFO and zeroes all outputs the next cycle.
- With `ADC9226_OTR_EN`: OTR=1 with raw 0xF00 → +2047; OTR=1 with raw 0x010 → −2048.
